// File: rtl/render_pkg.sv
// Shared rendering constants and types used by the triangle path and
// the frame-buffer transmitter.
package render_pkg;

    localparam int VERTEX_WIDTH = 48;
    localparam int TRI_WIDTH    = 3 * VERTEX_WIDTH;
    localparam int FB_PIXELS    = 2073600;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        PRESENT,
        DONE
    } fetch_state_t;

endpackage

// File: rtl/tri_ram.sv
// Simple dual-port triangle store: one write port, one registered read port.
// No reset so it maps onto block RAM; contents survive system reset.
module tri_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 144,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/triangle_fetch.sv
// Triangle memory loaded by the bootloader (even while in reset) plus a
// fetch engine that streams triangles 0..N-1 over valid/ready on start.
module triangle_fetch #(
    parameter int DEPTH      = 1024,
    parameter int TRI_WIDTH  = render_pkg::TRI_WIDTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [31:0]           wr_addr,
    input  logic [TRI_WIDTH-1:0]  wr_data,
    input  logic                  start,
    input  logic                  tri_ready,
    output logic                  tri_valid,
    output logic [TRI_WIDTH-1:0]  tri_data,
    output logic                  tri_last,
    output logic                  busy,
    output logic                  fetch_done,
    output logic [ADDR_WIDTH:0]   tri_count,
    output logic                  wr_overflow
);

    import render_pkg::*;

    logic                  in_range;
    logic [ADDR_WIDTH:0]   wr_idx_p1;
    logic [ADDR_WIDTH:0]   count_d, count_q;
    logic                  ovf_d, ovf_q;

    // Write-side bookkeeping is deliberately outside rst_n: the bootloader
    // loads triangles while it holds the system in reset.
    always_comb begin
        in_range  = wr_addr < 32'(DEPTH);
        wr_idx_p1 = {1'b0, wr_addr[ADDR_WIDTH-1:0]} + 1'b1;
        count_d   = count_q;
        ovf_d     = ovf_q;
        if (wr_en) begin
            if (!in_range) begin
                ovf_d = 1'b1;
            end else if (wr_addr[ADDR_WIDTH-1:0] == '0) begin
                count_d = (ADDR_WIDTH+1)'(1);
                ovf_d   = 1'b0;
            end else if (wr_idx_p1 > count_q) begin
                count_d = wr_idx_p1;
            end
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
        ovf_q   <= ovf_d;
    end

    fetch_state_t          state_d, state_q;
    logic [ADDR_WIDTH-1:0] idx_d, idx_q;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  is_last;

    tri_ram #(
        .DEPTH (DEPTH),
        .WIDTH (TRI_WIDTH),
        .AW    (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en && in_range),
        .wr_addr (wr_addr[ADDR_WIDTH-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (tri_data)
    );

    assign is_last = ({1'b0, idx_q} == count_q - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Reads are issued only on transitions into READ, so the registered RAM
    // output stays stable for the whole PRESENT stall.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rd_en   = 1'b0;
        rd_addr = idx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (count_q == '0) begin
                        state_d = DONE;
                    end else begin
                        rd_en   = 1'b1;
                        rd_addr = '0;
                        idx_d   = '0;
                        state_d = READ;
                    end
                end
            end
            READ: state_d = PRESENT;
            PRESENT: begin
                if (tri_ready) begin
                    if (is_last) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        rd_en   = 1'b1;
                        rd_addr = idx_q + 1'b1;
                        state_d = READ;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tri_valid  = (state_q == PRESENT);
        tri_last   = (state_q == PRESENT) && is_last;
        busy       = (state_q != IDLE);
        fetch_done = (state_q == DONE);
    end

    assign tri_count   = count_q;
    assign wr_overflow = ovf_q;

endmodule
